// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory: lane-mask encodings and default geometry.
// Used by dm_lane_merge and data_memory.
package dm_pkg;

   localparam int DM_ADDR_W = 6;
   localparam int DM_DATA_W = 32;
   localparam int DEPTH     = 2 ** DM_ADDR_W;

   typedef enum logic [1:0] {
      MASK_NONE = 2'b00,
      MASK_LO   = 2'b01,
      MASK_HI   = 2'b10,
      MASK_WORD = 2'b11
   } dm_mask_e;

endpackage : dm_pkg

// File: rtl/dm_lane_merge.sv
// Combinational halfword-lane merge: replaces the selected halves of old_word with din.
// Feeds both the store path and the optional display write-through preview.
module dm_lane_merge
   import dm_pkg::*;
#(
   parameter int DATA_W = DM_DATA_W
) (
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] din,
   input  logic [1:0]        mask,
   output logic [DATA_W-1:0] merged
);

   localparam int HALF_W = DATA_W / 2;

   always_comb begin
      // NOTE: assign a default first so every path drives merged and no latch is inferred.
      merged = old_word;
      // Ternary selects let an X mask poison the lane instead of silently keeping old data.
      merged[HALF_W-1:0]      = mask[0] ? din[HALF_W-1:0]      : old_word[HALF_W-1:0];
      merged[DATA_W-1:HALF_W] = mask[1] ? din[DATA_W-1:HALF_W] : old_word[DATA_W-1:HALF_W];
   end

endmodule : dm_lane_merge

// File: rtl/data_memory.sv
// MEM-stage data memory: synchronous masked store, combinational load port and display port.
// Optional macro DM_DISP_BYPASS_EN: display port previews a pending store to the same word.
module data_memory
   import dm_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DATA_W = DM_DATA_W   // must be even
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] disp_addr,
   input  logic [DATA_W-1:0] din,
   input  logic              store_en,
   input  logic [1:0]        mask,
   output logic [DATA_W-1:0] dout,
   output logic [DATA_W-1:0] disp_out
);

   localparam int MEM_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [DATA_W-1:0] write_word;
   logic              write_active;

   dm_lane_merge #(
      .DATA_W (DATA_W)
   ) u_lane_merge (
      .old_word (mem[addr]),
      .din      (din),
      .mask     (mask),
      .merged   (write_word)
   );

   assign write_active = store_en && (mask != MASK_NONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the whole array is cleared asynchronously, so this storage maps to flops, not a RAM macro.
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (write_active) begin
         // NOTE: non-blocking so reads this cycle see the old word and the new one lands after the edge.
         mem[addr] <= write_word;
      end
   end

   assign dout = mem[addr];

`ifdef DM_DISP_BYPASS_EN
   always_comb begin
      disp_out = mem[disp_addr];
      if (rst && write_active && (disp_addr == addr)) begin
         disp_out = write_word;
      end
   end
`else
   assign disp_out = mem[disp_addr];
`endif

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: reset sweep, table of store/read vectors,
// then hand-written same-cycle and async-reset sequences.
module tb_data_memory;
   import dm_pkg::*;

   logic        clk;
   logic        rst;
   logic [5:0]  addr;
   logic [5:0]  disp_addr;
   logic [31:0] din;
   logic        store_en;
   logic [1:0]  mask;
   logic [31:0] dout;
   logic [31:0] disp_out;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        store_en;
      logic [1:0]  mask;
      logic [5:0]  addr;
      logic [31:0] din;
      logic [5:0]  disp_addr;
      logic [31:0] exp_dout;
      logic [31:0] exp_disp;
   } vec_t;

   vec_t vecs [10];

   data_memory #(
      .ADDR_W (6),
      .DATA_W (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .disp_addr (disp_addr),
      .din       (din),
      .store_en  (store_en),
      .mask      (mask),
      .dout      (dout),
      .disp_out  (disp_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      logic [31:0] exp_pre_disp;

      // Reset state: store attempted while rst is low must not land
      rst       = 1'b0;
      store_en  = 1'b1;
      mask      = MASK_WORD;
      din       = 32'hFFFF_FFFF;
      addr      = 6'd5;
      disp_addr = 6'd5;
      @(posedge clk);
      #1;
      for (int i = 0; i < DEPTH; i++) begin
         addr      = 6'(i);
         disp_addr = 6'(DEPTH - 1 - i);
         #1;
         check($sformatf("reset_dout[%0d]", i), dout, 32'h0);
         check($sformatf("reset_disp[%0d]", DEPTH - 1 - i), disp_out, 32'h0);
      end

      // {store_en, mask, addr, din, disp_addr, exp_dout, exp_disp}; checked after the edge
      vecs[0] = '{1'b1, 2'b11, 6'd5,  32'hDEAD_BEEF, 6'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 2'b01, 6'd5,  32'h1234_5678, 6'd5,  32'hDEAD_5678, 32'hDEAD_5678};
      vecs[2] = '{1'b1, 2'b10, 6'd5,  32'hCAFE_0000, 6'd5,  32'hCAFE_5678, 32'hCAFE_5678};
      vecs[3] = '{1'b1, 2'b00, 6'd5,  32'hFFFF_FFFF, 6'd5,  32'hCAFE_5678, 32'hCAFE_5678};
      vecs[4] = '{1'b0, 2'b11, 6'd5,  32'h0000_0000, 6'd5,  32'hCAFE_5678, 32'hCAFE_5678};
      vecs[5] = '{1'b1, 2'b11, 6'd63, 32'h0000_0001, 6'd5,  32'h0000_0001, 32'hCAFE_5678};
      vecs[6] = '{1'b1, 2'b11, 6'd0,  32'h0000_0002, 6'd63, 32'h0000_0002, 32'h0000_0001};
      vecs[7] = '{1'b0, 2'b00, 6'd0,  32'hAAAA_AAAA, 6'd63, 32'h0000_0002, 32'h0000_0001};
      vecs[8] = '{1'b1, 2'b01, 6'd10, 32'hFFFF_AAAA, 6'd10, 32'h0000_AAAA, 32'h0000_AAAA};
      vecs[9] = '{1'b1, 2'b10, 6'd11, 32'h5555_FFFF, 6'd10, 32'h5555_0000, 32'h0000_AAAA};

      @(negedge clk);
      rst = 1'b1;
      for (int v = 0; v < 10; v++) begin
         @(negedge clk);
         store_en  = vecs[v].store_en;
         mask      = vecs[v].mask;
         addr      = vecs[v].addr;
         din       = vecs[v].din;
         disp_addr = vecs[v].disp_addr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_dout", v), dout, vecs[v].exp_dout);
         check($sformatf("vec%0d_disp", v), disp_out, vecs[v].exp_disp);
      end

      // Same-cycle read of the write target: old value before the edge, new after
`ifdef DM_DISP_BYPASS_EN
      exp_pre_disp = 32'hA5A5_A5A5;
`else
      exp_pre_disp = 32'h0;
`endif
      @(negedge clk);
      store_en  = 1'b1;
      mask      = MASK_WORD;
      addr      = 6'd20;
      disp_addr = 6'd20;
      din       = 32'hA5A5_A5A5;
      #1;
      check("rbw_dout_pre", dout, 32'h0);
      check("rbw_disp_pre", disp_out, exp_pre_disp);
      @(posedge clk);
      #1;
      check("rbw_dout_post", dout, 32'hA5A5_A5A5);
      check("rbw_disp_post", disp_out, 32'hA5A5_A5A5);

      // Async reset between edges clears everything without a clock edge
      @(negedge clk);
      store_en  = 1'b0;
      addr      = 6'd5;
      disp_addr = 6'd63;
      #1;
      check("pre_arst_dout", dout, 32'hCAFE_5678);
      rst = 1'b0;
      #1;
      check("arst_dout", dout, 32'h0);
      check("arst_disp", disp_out, 32'h0);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_arst_dout", dout, 32'h0);
      check("post_arst_disp", disp_out, 32'h0);
      addr = 6'd20;
      #1;
      check("post_arst_dout20", dout, 32'h0);

      // First store after release: lower lane only, upper stays at the cleared value
      @(negedge clk);
      store_en  = 1'b1;
      mask      = MASK_LO;
      addr      = 6'd5;
      disp_addr = 6'd5;
      din       = 32'hFFFF_1234;
      @(posedge clk);
      #1;
      check("post_arst_store_dout", dout, 32'h0000_1234);
      check("post_arst_store_disp", disp_out, 32'h0000_1234);
      @(negedge clk);
      store_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_data_memory
